risc_controller: RTL and testbench
==================================

# risc_controller

Phase sequencer for the 8-bit RISC core. It owns the address multiplexor select and every load, read, write and bus-drive strobe in the datapath. It steps through a fixed 8-phase instruction cycle: three fetch phases, one idle phase, four execute phases. It decodes the 3-bit opcode from the instruction register, and a HLT instruction latches the core into a halted state until reset.

## Interface
- `OPC_WIDTH`, default 3: opcode width. Only the value 3 is supported.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `opcode` input `OPC_WIDTH`: opcode field of the instruction register.
- `zero` input 1: accumulator-zero flag.
- `sel` output 1: address mux select.
  - 1 selects the PC address (mux `in1`).
  - 0 selects the IR operand address (mux `in0`).
- `rd` output 1: memory read enable.
- `ld_ir` output 1: instruction register load.
- `inc_pc` output 1: program counter increment.
- `ld_pc` output 1: program counter load (jump).
- `ld_ac` output 1: accumulator load.
- `wr` output 1: memory write strobe.
- `data_e` output 1: accumulator drives the data bus.
- `halt` output 1: core halted or halting.
- `phase` output 3: current phase number, for debug and bench.

## Operation
- **Opcodes:**
  - HLT = 0, SKZ = 1, ADD = 2, AND = 3, XOR = 4, LDA = 5, STO = 6, JMP = 7.
  - `aluop` = ADD | AND | XOR | LDA.
- **State:**
  - 3-bit phase counter, 0..7, increments by 1 each clock and wraps 7 -> 0.
  - 1-bit `halted` register.
- **Outputs** are combinational from `phase`, `opcode`, `zero` and `halted`. Any strobe not listed for a phase is 0.
  - Phase 0, INST_ADDR: `sel`=1.
  - Phase 1, INST_FETCH: `sel`=1, `rd`=1.
  - Phase 2, INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
  - Phase 3, IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
  - Phase 4, OP_ADDR: `inc_pc`=1, `halt`=(opcode==HLT).
  - Phase 5, OP_FETCH: `rd`=`aluop`.
  - Phase 6, ALU_OP:
    - `rd`=`aluop`.
    - `inc_pc`=(opcode==SKZ && `zero`).
    - `ld_pc`=(opcode==JMP).
    - `data_e`=(opcode==STO).
  - Phase 7, STORE:
    - `rd`=`aluop`, `ld_ac`=`aluop`.
    - `ld_pc`=(opcode==JMP).
    - `wr`=(opcode==STO), `data_e`=(opcode==STO).
- **Halt entry:** on the rising edge that ends phase 4 with opcode==HLT, set `halted`=1 and freeze `phase` at 4.
- **While halted:**
  - `halt`=1.
  - All other strobes are 0, including `sel` and `inc_pc`.
  - `phase` holds at 4.
  - `opcode` and `zero` are ignored.
- **Halt exit:** only by `rst_n` low.
- **SKZ with `zero`=0:** the controller performs no action beyond the phase-4 increment.
- **Mutual exclusion:** `wr` and `rd` are never both 1. `ld_ir` is never 1 outside phases 2-3.

## Timing
- **Reset:** `rst_n` low forces `phase`=0 and `halted`=0 immediately, without waiting for a clock.
  - Outputs during reset: `sel`=1; `rd`, `ld_ir`, `inc_pc`, `ld_pc`, `ld_ac`, `wr`, `data_e` and `halt` all 0; `phase`=0.
- **Reset mid-instruction:** any phase, halted or not, returns to phase 0 with the same output values. No partial strobe persists after `rst_n` falls.
- **Reset release:** the first rising edge with `rst_n` high moves phase 0 -> 1.
- **Instruction length:** exactly 8 clocks. The IR is captured at the end of phases 2 and 3, so `opcode` is stable from phase 4.
- **PC increments per instruction:**
  - One, at the end of phase 4.
  - A second one, at the end of phase 6, for a taken SKZ.
  - A JMP asserts `ld_pc` in phases 6-7, and the load wins over any increment.
- **Write strobe:** `wr` is a single-phase pulse (phase 7). `data_e` leads it by one phase.
- **Output glitches:** outputs change only after clock edges or `rst_n` edges. The exception is phase-6 `inc_pc`, which follows `zero` combinationally.

## Test plan
- **Reset and free run:** assert `rst_n` low mid-phase 5, then release with opcode=ADD -> `phase`=0 and `sel`=1 at once, and all other strobes 0. After release, `phase` sequences 1..7,0 over 8 clocks. Phases 5-7 show `rd`=1 and phase 7 shows `ld_ac`=1.
- **STO:** opcode=6 -> `data_e`=1 in phases 6-7 and `wr`=1 in phase 7 only. `rd` stays 0 in phases 5-7.
- **SKZ:** opcode=1 with `zero`=1 -> `inc_pc`=1 in phases 4 and 6. Repeating with `zero`=0 -> `inc_pc`=1 in phase 4 only.
- **JMP:** opcode=7 -> `ld_pc`=1 in phases 6 and 7. `rd`, `ld_ac` and `wr` stay 0.
- **HLT:** opcode=0 -> `halt`=1 in phase 4. After the edge, `phase` stays 4 for more than 20 clocks with `halt`=1 and all other strobes 0. Changing opcode to ADD has no effect. Pulsing `rst_n` low returns to `phase`=0 with `halt`=0.
- **Assertions on every cycle:** never `rd`&`wr`. `ld_ir` only in phases 2-3. `sel`=1 exactly in phases 0-3 when not halted.

Source files
------------

// File: rtl/risc_controller.sv
// Phase sequencer for the 8-bit RISC core: steps a fixed 8-phase instruction
// cycle and decodes the opcode into datapath strobes; HLT freezes it until reset.
module risc_controller #(
  parameter int OPC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPC_WIDTH-1:0] opcode,
  input  logic                 zero,
  output logic                 sel,
  output logic                 rd,
  output logic                 ld_ir,
  output logic                 inc_pc,
  output logic                 ld_pc,
  output logic                 ld_ac,
  output logic                 wr,
  output logic                 data_e,
  output logic                 halt,
  output logic [2:0]           phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  phase_e  state, state_next;
  logic    halted, halted_next;
  opcode_e op;
  logic    aluop;

  assign op    = opcode_e'(opcode[2:0]);
  assign aluop = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign phase = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    state_next  = phase_e'(state + 3'd1);
    halted_next = halted;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;

    if (halted) begin
      // Halted: phase frozen at OP_ADDR, every strobe but halt suppressed.
      state_next = state;
      halt       = 1'b1;
    end else begin
      unique case (state)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          if (op == OP_HLT) begin
            halt        = 1'b1;
            halted_next = 1'b1;
            state_next  = state;
          end
        end
        OP_FETCH: rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (op == OP_SKZ) && zero;
          ld_pc  = (op == OP_JMP);
          data_e = (op == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (op == OP_JMP);
          wr     = (op == OP_STO);
          data_e = (op == OP_STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: directed opcode tables, HLT and reset
// sequences, then randomized opcodes/zero/resets against a behavioural model.
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int vectors = 0;
  int misses  = 0;
  int m_ph    = 0;
  bit m_h     = 1'b0;

  risc_controller #(.OPC_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  // Strobe order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}, then phase.
  function automatic logic [11:0] model_out(int ph, logic [2:0] op, logic z, bit h);
    logic       alu;
    logic [8:0] s;
    if (h) return {9'b000000001, 3'd4};
    alu  = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    s    = '0;
    s[8] = (ph < 4);
    s[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    s[6] = (ph == 2 || ph == 3);
    s[5] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    s[4] = (op == 3'd7) && (ph >= 6);
    s[3] = alu && (ph == 7);
    s[2] = (op == 3'd6) && (ph == 7);
    s[1] = (op == 3'd6) && (ph >= 6);
    s[0] = (ph == 4) && (op == 3'd0);
    return {s, 3'(ph)};
  endfunction

  function automatic logic [11:0] dut_out();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = dut_out();
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s @%0t: got %b_%0d required %b_%0d", name, $time,
               got[11:3], got[2:0], exp[11:3], exp[2:0]);
    end
  endtask

  task automatic check_model(input string name);
    check(name, model_out(m_ph, opcode, zero, m_h));
  endtask

  task automatic check_invariants();
    logic ok;
    ok = !(rd && wr) && (!ld_ir || phase == 3'd2 || phase == 3'd3) &&
         (sel == (!m_h && m_ph < 4));
    vectors++;
    if (!ok) begin
      misses++;
      $display("FAIL invariants @%0t: rd=%b wr=%b ld_ir=%b sel=%b phase=%0d required no rd&wr, ld_ir in 2-3, sel=%b",
               $time, rd, wr, ld_ir, sel, phase, (!m_h && m_ph < 4));
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic tick();
    if (rst_n !== 1'b1) begin
      m_ph = 0;
      m_h  = 1'b0;
    end else if (!m_h) begin
      if (m_ph == 4 && opcode == 3'd0) m_h = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m_ph  = 0;
    m_h   = 1'b0;
    #1;
  endtask

  typedef struct {
    string            name;
    logic [2:0]       op;
    logic             z;
    logic [3:0][8:0]  ex;   // index 0 = phase 4 ... index 3 = phase 7
  } vec_t;

  vec_t            tbl[6];
  logic [3:0][8:0] fetch;
  logic [11:0]     exp;

  initial begin
    fetch  = {9'b111000000, 9'b111000000, 9'b110000000, 9'b100000000};
    tbl[0] = '{"ADD",     3'd2, 1'b0, {9'b010001000, 9'b010000000, 9'b010000000, 9'b000100000}};
    tbl[1] = '{"STO",     3'd6, 1'b1, {9'b000000110, 9'b000000010, 9'b000000000, 9'b000100000}};
    tbl[2] = '{"SKZ_z1",  3'd1, 1'b1, {9'b000000000, 9'b000100000, 9'b000000000, 9'b000100000}};
    tbl[3] = '{"SKZ_z0",  3'd1, 1'b0, {9'b000000000, 9'b000000000, 9'b000000000, 9'b000100000}};
    tbl[4] = '{"JMP",     3'd7, 1'b1, {9'b000010000, 9'b000010000, 9'b000000000, 9'b000100000}};
    tbl[5] = '{"LDA",     3'd5, 1'b1, {9'b010001000, 9'b010000000, 9'b010000000, 9'b000100000}};

    opcode = 3'd2;
    zero   = 1'b0;
    rst_n  = 1'b0;
    #2;
    check("reset_initial", {9'b100000000, 3'd0});
    rst_n = 1'b1;

    // Run into phase 5, then pull reset mid-phase and check it acts at once.
    for (int c = 0; c < 5; c++) tick();
    check("pre_reset_phase5", {9'b010000000, 3'd5});
    assert_reset();
    check("async_reset_mid_phase5", {9'b100000000, 3'd0});
    tick();
    check("reset_held", {9'b100000000, 3'd0});
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 6; i++) begin
      opcode = tbl[i].op;
      zero   = tbl[i].z;
      for (int p = 0; p < 8; p++) begin
        #1;
        exp = (p < 4) ? {fetch[p], 3'(p)} : {tbl[i].ex[p-4], 3'(p)};
        check({"tbl_", tbl[i].name}, exp);
        check_model({"model_", tbl[i].name});
        check_invariants();
        tick();
      end
    end

    // HLT: halt shows in phase 4, then the core freezes until reset.
    opcode = 3'd0;
    for (int p = 0; p < 5; p++) begin
      #1;
      check_model("hlt_approach");
      if (p < 4) tick();
    end
    check("hlt_phase4", {9'b000100001, 3'd4});
    tick();
    for (int c = 0; c < 25; c++) begin
      opcode = 3'd2;
      zero   = 1'($urandom);
      #1;
      check("halted_hold", {9'b000000001, 3'd4});
      tick();
    end
    assert_reset();
    check("reset_from_halt", {9'b100000000, 3'd0});
    tick();
    rst_n = 1'b1;
    #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (m_ph == 0 && !m_h) begin
        opcode = 3'($urandom_range(0, 7));
        if (opcode == 3'd0 && $urandom_range(0, 3) != 0) opcode = 3'd2;
      end
      zero = 1'($urandom);
      if ((m_h && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
        assert_reset();
        check_model("rand_reset");
        tick();
        rst_n = 1'b1;
      end
      #1;
      check_model("rand");
      check_invariants();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
